id_stage: RTL

Decode-stage front end of the five-stage LoongArch pipeline. It is the consumer side of the IF→ID handshake and IFreg bus, and the producer of BR_BUS back to IF. It latches the fetched instruction and reads rj/rd operands from the register file. It resolves all branch and jump instructions in ID and cancels the wrong-path instruction already fetched by IF, then passes the instruction to EX through the ID→EX handshake.

---
 rtl/id_stage_pkg.sv | 38 +++
 rtl/id_stage_br_cond.sv | 26 ++
 rtl/id_stage.sv | 98 +++++++++
 3 files changed

// File: rtl/id_stage_pkg.sv
// Shared LoongArch pipeline constants: branch bus width, branch opcodes and
// the condition-select encoding consumed by br_cond.
package id_stage_pkg;

    localparam int BR_BUS_LEN = 33;

    localparam logic [5:0] OP_JIRL = 6'h13;
    localparam logic [5:0] OP_B    = 6'h14;
    localparam logic [5:0] OP_BL   = 6'h15;
    localparam logic [5:0] OP_BEQ  = 6'h16;
    localparam logic [5:0] OP_BNE  = 6'h17;
    localparam logic [5:0] OP_BLT  = 6'h18;
    localparam logic [5:0] OP_BGE  = 6'h19;
    localparam logic [5:0] OP_BLTU = 6'h1a;
    localparam logic [5:0] OP_BGEU = 6'h1b;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_EQ     = 3'd1;
    localparam logic [2:0] COND_NE     = 3'd2;
    localparam logic [2:0] COND_LT     = 3'd3;
    localparam logic [2:0] COND_GE     = 3'd4;
    localparam logic [2:0] COND_LTU    = 3'd5;
    localparam logic [2:0] COND_GEU    = 3'd6;

    // Non-branch opcodes map to COND_ALWAYS; is_branch gates them off.
    function automatic logic [2:0] br_cond_sel(input logic [5:0] op);
        case (op)
            OP_BEQ:  br_cond_sel = COND_EQ;
            OP_BNE:  br_cond_sel = COND_NE;
            OP_BLT:  br_cond_sel = COND_LT;
            OP_BGE:  br_cond_sel = COND_GE;
            OP_BLTU: br_cond_sel = COND_LTU;
            OP_BGEU: br_cond_sel = COND_GEU;
            default: br_cond_sel = COND_ALWAYS;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_br_cond.sv
// Branch condition evaluator: compares rj against rd under the selected
// condition. Purely combinational.
module br_cond
    import id_stage_pkg::*;
(
    input  logic [31:0] rj,
    input  logic [31:0] rd,
    input  logic [2:0]  sel,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (sel)
            COND_ALWAYS: taken = 1'b1;
            COND_EQ:     taken = (rj == rd);
            COND_NE:     taken = (rj != rd);
            COND_LT:     taken = ($signed(rj) <  $signed(rd));
            COND_GE:     taken = ($signed(rj) >= $signed(rd));
            COND_LTU:    taken = (rj <  rd);
            COND_GEU:    taken = (rj >= rd);
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// Decode-stage front end: latches the IF instruction, reads rj/rd, resolves
// branches in ID and sends the redirect back to IF on BR_BUS.
module id_stage
    import id_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  IF_ready_go,
    input  logic                  IFreg_valid,
    input  logic [31:0]           IFreg_pc,
    input  logic [31:0]           IFreg_inst,
    output logic                  ID_allow_in,
    output logic [BR_BUS_LEN-1:0] BR_BUS,
    output logic [4:0]            rf_raddr1,
    output logic [4:0]            rf_raddr2,
    input  logic [31:0]           rf_rdata1,
    input  logic [31:0]           rf_rdata2,
    input  logic                  id_stall,
    input  logic                  EX_allow_in,
    output logic                  IDreg_valid,
    output logic [31:0]           IDreg_pc,
    output logic [31:0]           IDreg_inst,
    output logic                  IDreg_link
);

    // Handshake: a slot moves from producer to consumer on the edge where the
    // producer's valid and the consumer's allow_in are both high; valid never
    // depends on allow_in, and a held slot keeps pc/inst stable until it moves.
    logic        ID_valid;
    logic [31:0] ID_pc;
    logic [31:0] ID_inst;

    logic        ID_ready_go;
    logic        ID_fire;
    logic [5:0]  opcode;
    logic        is_jirl;
    logic        is_b;
    logic        is_bl;
    logic        is_branch;
    logic [2:0]  cond_sel;
    logic        cond_taken;
    logic        br_taken;
    logic [31:0] offs16_ext;
    logic [31:0] offs26_ext;
    logic [31:0] br_base;
    logic [31:0] br_offs;
    logic [31:0] br_target;

    assign ID_ready_go = ~id_stall;
    assign ID_allow_in = ~ID_valid | (ID_ready_go & EX_allow_in);
    assign ID_fire     = ID_valid & ID_ready_go & EX_allow_in;

    assign opcode    = ID_inst[31:26];
    assign is_jirl   = (opcode == OP_JIRL);
    assign is_b      = (opcode == OP_B);
    assign is_bl     = (opcode == OP_BL);
    assign is_branch = (opcode >= OP_JIRL) && (opcode <= OP_BGEU);
    assign cond_sel  = br_cond_sel(opcode);

    assign rf_raddr1 = ID_inst[9:5];
    assign rf_raddr2 = is_branch ? ID_inst[4:0] : ID_inst[14:10];

    br_cond u_br_cond (
        .rj    (rf_rdata1),
        .rd    (rf_rdata2),
        .sel   (cond_sel),
        .taken (cond_taken)
    );

    // Offsets are word offsets; the adder wraps modulo 2^32.
    assign offs16_ext = {{14{ID_inst[25]}}, ID_inst[25:10], 2'b00};
    assign offs26_ext = {{4{ID_inst[9]}}, ID_inst[9:0], ID_inst[25:10], 2'b00};
    assign br_base    = is_jirl ? rf_rdata1 : ID_pc;
    assign br_offs    = (is_b | is_bl) ? offs26_ext : offs16_ext;
    assign br_target  = br_base + br_offs;

    // Qualified by ID_fire so a stalled branch redirects only once, as it leaves.
    assign br_taken = ID_fire & is_branch & cond_taken;
    assign BR_BUS   = {br_taken, br_target};

    always_ff @(posedge clk) begin
        if (reset) begin
            ID_valid <= 1'b0;
            ID_pc    <= 32'h0;
            ID_inst  <= 32'h0;
        end else if (ID_allow_in) begin
            ID_valid <= IFreg_valid & IF_ready_go & ~br_taken;
            ID_pc    <= IFreg_pc;
            ID_inst  <= IFreg_inst;
        end
    end

    assign IDreg_valid = ID_valid & ID_ready_go;
    assign IDreg_pc    = ID_pc;
    assign IDreg_inst  = ID_inst;
    assign IDreg_link  = ID_valid & (is_bl | is_jirl);

endmodule
